// File: rtl/i2s_tx_sequencer.sv
// I2S (Philips format) transmit sequencer: one stereo sample per rate-strobed frame,
// 2x32-bit slots, MSB one bclk after the lrck edge, with a single-entry holding register.
module i2s_tx_sequencer #(
  parameter int DW       = 16,
  parameter int BCLK_DIV = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rate,
  input  logic [DW-1:0] sample_l,
  input  logic [DW-1:0] sample_r,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          bclk,
  output logic          lrck,
  output logic          sdata,
  output logic          active,
  output logic          underflow,
  output logic          frame_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int             DIV_W    = $clog2(BCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [5:0]     LAST_L   = 6'(DW);
  localparam logic [5:0]     FIRST_R  = 6'd33;
  localparam logic [5:0]     LAST_R   = 6'(32 + DW);

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic              hold_full;
  logic [DW-1:0]     hold_l;
  logic [DW-1:0]     hold_r;
  logic [2*DW-1:0]   shift_reg;

  logic              div_wrap;
  logic              terminal;
  logic [DIV_W-1:0]  div_nxt;
  logic [5:0]        bit_nxt;
  logic              send_bit;

  // Next counter position for the "advance" case; terminal is handled separately.
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    terminal = div_wrap && (bit_cnt == 6'd63);
    div_nxt  = div_wrap ? '0 : div_cnt + DIV_W'(1);
    bit_nxt  = div_wrap ? bit_cnt + 6'd1 : bit_cnt;
    send_bit = ((bit_nxt >= 6'd1) && (bit_nxt <= LAST_L)) ||
               ((bit_nxt >= FIRST_R) && (bit_nxt <= LAST_R));
  end

  assign sample_ready = ~hold_full;
  assign active       = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      // NOTE: the holding and shift registers are reset so a mid-frame reset can never leak a stale sample.
      hold_l    <= '0;
      hold_r    <= '0;
      shift_reg <= '0;
      bclk      <= 1'b0;
      lrck      <= 1'b0;
      sdata     <= 1'b0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      underflow <= 1'b0;
      frame_err <= 1'b0;

      if (sample_valid && !hold_full) begin
        hold_l    <= sample_l;
        hold_r    <= sample_r;
        hold_full <= 1'b1;
      end

      if (rate) begin
        // A strobe anywhere but the terminal point is a resync, not a normal start.
        if (state == RUN && !terminal) frame_err <= 1'b1;
        state   <= RUN;
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        lrck    <= 1'b0;
        sdata   <= 1'b0;
        if (hold_full) begin
          shift_reg <= {hold_l, hold_r};
          hold_full <= 1'b0;
        end else begin
          shift_reg <= '0;
          underflow <= 1'b1;
        end
      end else if (state == RUN) begin
        if (terminal) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          div_cnt   <= '0;
          bit_cnt   <= '0;
          bclk      <= 1'b0;
          lrck      <= 1'b0;
          sdata     <= 1'b0;
        end else begin
          div_cnt <= div_nxt;
          bit_cnt <= bit_nxt;
          bclk    <= (div_nxt >= DIV_HALF);
          lrck    <= bit_nxt[5];
          // sdata only moves at a bit boundary, i.e. on the bclk falling edge.
          if (div_wrap) begin
            if (send_bit) begin
              sdata     <= shift_reg[2*DW-1];
              shift_reg <= {shift_reg[2*DW-2:0], 1'b0};
            end else begin
              sdata <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: a cycle model checks every output each clk,
// and directed steps check frame words and the boundary cases against hand-computed values.
module tb_i2s_tx_sequencer;

  localparam int DW       = 16;
  localparam int BCLK_DIV = 6;
  localparam int FRAME    = 64 * BCLK_DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rate = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_l = '0;
  logic [DW-1:0] sample_r = '0;
  logic          sample_ready, bclk, lrck, sdata, active, underflow, frame_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_run, m_full, exp_uf, exp_fe;
  int              m_c;
  logic [DW-1:0]   m_l, m_r;
  logic [63:0]     m_word, cap;
  logic [2*DW-1:0] prod_q[$];

  i2s_tx_sequencer #(.DW(DW), .BCLK_DIV(BCLK_DIV)) dut (
    .clk(clk), .reset(reset), .rate(rate),
    .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrck(lrck), .sdata(sdata),
    .active(active), .underflow(underflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serial word as sent, index 63-b holding bit b of the frame.
  function automatic logic [63:0] mk_word(input logic [DW-1:0] l, input logic [DW-1:0] r);
    logic [63:0] w = '0;
    for (int i = 0; i < DW; i++) begin
      w[62-i] = l[DW-1-i];
      w[30-i] = r[DW-1-i];
    end
    return w;
  endfunction

  task automatic drive_prod();
    if (prod_q.size() > 0) begin
      sample_valid = 1'b1;
      {sample_l, sample_r} = prod_q[0];
    end else begin
      sample_valid = 1'b0;
      sample_l = DW'($urandom);
      sample_r = DW'($urandom);
    end
  endtask

  task automatic step();
    bit            r_rate, r_reset, xfer;
    logic [DW-1:0] r_l, r_r;
    logic [6:0]    exp_v;
    r_rate  = rate;
    r_reset = reset;
    xfer    = sample_valid && !m_full;
    r_l     = sample_l;
    r_r     = sample_r;
    @(posedge clk);
    #1;
    exp_uf = 1'b0;
    exp_fe = 1'b0;
    if (r_reset) begin
      m_run = 1'b0; m_c = 0; m_full = 1'b0; m_word = '0;
    end else begin
      if (r_rate) begin
        exp_fe = m_run && (m_c != FRAME - 1);
        m_run  = 1'b1;
        m_c    = 0;
        cap    = '0;
        if (m_full) begin
          m_word = mk_word(m_l, m_r);
          m_full = 1'b0;
        end else begin
          m_word = '0;
          exp_uf = 1'b1;
        end
      end else if (m_run) begin
        if (m_c == FRAME - 1) begin
          exp_fe = 1'b1; m_run = 1'b0; m_c = 0;
        end else begin
          m_c++;
        end
      end
      if (xfer) begin
        m_l = r_l; m_r = r_r; m_full = 1'b1;
        void'(prod_q.pop_front());
      end
    end
    exp_v = {m_run && ((m_c % BCLK_DIV) >= BCLK_DIV / 2),
             m_run && ((m_c / BCLK_DIV) >= 32),
             m_run ? m_word[63 - m_c / BCLK_DIV] : 1'b0,
             m_run, exp_uf, exp_fe, !m_full};
    check("cycle{bclk,lrck,sdata,active,uf,ferr,ready}",
          64'({bclk, lrck, sdata, active, underflow, frame_err, sample_ready}), 64'(exp_v));
    if (m_run && (m_c % BCLK_DIV) == BCLK_DIV / 2) cap[63 - m_c / BCLK_DIV] = sdata;
    drive_prod();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic frame_start();
    rate = 1'b1;
    step();
    rate = 1'b0;
  endtask

  task automatic run_to_end();
    for (int i = 0; i < FRAME && m_run && m_c != FRAME - 1; i++) step();
  endtask

  initial begin
    drive_prod();
    steps(4);
    reset = 1'b0;
    check("reset_ready", 64'(sample_ready), 64'd1);
    check("reset_outputs", 64'({bclk, lrck, sdata, active, underflow, frame_err}), 64'd0);

    // Normal stereo frame
    prod_q.push_back({16'hA5F0, 16'h0F0F});
    drive_prod();
    step();
    check("preload_ready_low", 64'(sample_ready), 64'd0);
    frame_start();
    check("f1_underflow", 64'(underflow), 64'd0);
    check("f1_active", 64'(active), 64'd1);
    steps(191);
    check("f1_lrck_clk191", 64'(lrck), 64'd0);
    step();
    check("f1_lrck_clk192", 64'(lrck), 64'd1);
    run_to_end();
    check("f1_word", cap, {1'b0, 16'hA5F0, 16'h0000, 16'h0F0F, 15'h0000});

    // Underflow
    frame_start();
    check("f2_underflow", 64'(underflow), 64'd1);
    check("f2_frame_err", 64'(frame_err), 64'd0);
    step();
    check("f2_underflow_width", 64'(underflow), 64'd0);
    check("f2_active", 64'(active), 64'd1);
    run_to_end();
    check("f2_word", cap, 64'd0);

    // Backpressure; first value transfers on the same edge as the frame start
    prod_q.push_back({16'h8001, 16'h7FFE});
    prod_q.push_back({16'h1234, 16'hFEDC});
    prod_q.push_back({16'hFFFF, 16'h0001});
    drive_prod();
    frame_start();
    check("f3_underflow_simul", 64'(underflow), 64'd1);
    check("f3_ready_low", 64'(sample_ready), 64'd0);
    run_to_end();
    check("f3_word", cap, 64'd0);
    frame_start();
    check("f4_underflow", 64'(underflow), 64'd0);
    check("f4_ready_after_start", 64'(sample_ready), 64'd1);
    step();
    check("f4_second_accepted", 64'(sample_ready), 64'd0);
    run_to_end();
    check("f4_word", cap, {1'b0, 16'h8001, 16'h0000, 16'h7FFE, 15'h0000});
    frame_start();
    run_to_end();
    check("f5_word", cap, {1'b0, 16'h1234, 16'h0000, 16'hFEDC, 15'h0000});
    frame_start();
    prod_q.push_back({16'h4000, 16'h8000});
    drive_prod();
    run_to_end();
    check("f6_word", cap, {1'b0, 16'hFFFF, 16'h0000, 16'h0001, 15'h0000});

    // Early rate at clk 200 of frame 7
    frame_start();
    prod_q.push_back({16'hC35A, 16'h5AC3});
    drive_prod();
    steps(199);
    check("f7_lrck_before_early", 64'(lrck), 64'd1);
    frame_start();
    check("f7_early_frame_err", 64'(frame_err), 64'd1);
    check("f7_early_lrck", 64'(lrck), 64'd0);
    check("f7_early_bclk", 64'(bclk), 64'd0);
    check("f7_early_underflow", 64'(underflow), 64'd0);
    step();
    check("f7_frame_err_width", 64'(frame_err), 64'd0);
    run_to_end();
    check("f8_word", cap, {1'b0, 16'hC35A, 16'h0000, 16'h5AC3, 15'h0000});

    // Missing rate
    step();
    check("miss_frame_err", 64'(frame_err), 64'd1);
    check("miss_active", 64'(active), 64'd0);
    steps(10);
    check("miss_idle_outputs", 64'({bclk, lrck, sdata, active, frame_err}), 64'd0);
    frame_start();
    check("f9_restart_active", 64'(active), 64'd1);
    check("f9_underflow", 64'(underflow), 64'd1);

    // Mid-frame reset at bit 40 with a sample held
    prod_q.push_back({16'hAAAA, 16'h5555});
    drive_prod();
    steps(240);
    check("pre_reset_held", 64'(sample_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_outputs", 64'({bclk, lrck, sdata, active, underflow, frame_err}), 64'd0);
    check("midreset_ready", 64'(sample_ready), 64'd1);
    step();
    frame_start();
    check("post_reset_underflow", 64'(underflow), 64'd1);
    steps(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
